// File: rtl/sync_adder_if.sv
// sync_adder_if: operand/result bundle for sync_adder.
// The master side drives enable/a/b and observes sum/valid; the slave side
// (the adder) does the reverse. When SYNC_ADDER_STATS_EN is defined the
// bundle also carries the two statistics counters produced by the adder.
interface sync_adder_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   sum;
  logic             valid;
`ifdef SYNC_ADDER_STATS_EN
  logic [31:0]      result_count;
  logic [31:0]      carry_count;
`endif

`ifdef SYNC_ADDER_STATS_EN
  modport master (output enable, a, b, input sum, valid, result_count, carry_count);
  modport slave  (input enable, a, b, output sum, valid, result_count, carry_count);
`else
  modport master (output enable, a, b, input sum, valid);
  modport slave  (input enable, a, b, output sum, valid);
`endif
endinterface

// File: rtl/sync_adder.sv
// sync_adder: registered unsigned adder with full-precision sum (carry kept
// in the MSB) and a valid strobe aligned with each result.
// Pipeline depth is LATENCY stages (1..4, anything else falls back to 1).
// Every stage carries its own valid bit; a stage's data only moves when the
// valid feeding it is high, so sum holds the last result while idle.
// Optional macro SYNC_ADDER_STATS_EN adds saturating result_count and
// carry_count outputs on the interface.
module sync_adder #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input logic        clk,
  input logic        rst,
  sync_adder_if.slave bus
);

  localparam int LAT = ((LATENCY >= 1) && (LATENCY <= 4)) ? LATENCY : 1;

  // Zero-extend both operands so the carry lands in the extra MSB.
  function automatic logic [WIDTH:0] add_full(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == '1) ? c : c + 32'd1;
  endfunction

  logic [WIDTH:0] sum_p [LAT];
  logic           vld_p [LAT];

  // Stage 0 samples operands on enable; later stages shift forward on their incoming valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        vld_p[i] <= 1'b0;
        sum_p[i] <= '0;
      end
    end else begin
      // stage 0: operand sample and add
      vld_p[0] <= bus.enable;
      if (bus.enable) begin
        sum_p[0] <= add_full(bus.a, bus.b);
      end
      // stages 1..LAT-1: delay line, data held when no valid arrives
      for (int i = 1; i < LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) begin
          sum_p[i] <= sum_p[i-1];
        end
      end
    end
  end

  assign bus.sum   = sum_p[LAT-1];
  assign bus.valid = vld_p[LAT-1];

`ifdef SYNC_ADDER_STATS_EN
  logic [31:0] result_cnt;
  logic [31:0] carry_cnt;

  // Count delivered results and those with carry-out, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_cnt <= '0;
      carry_cnt  <= '0;
    end else if (vld_p[LAT-1]) begin
      result_cnt <= sat_inc(result_cnt);
      if (sum_p[LAT-1][WIDTH]) begin
        carry_cnt <= sat_inc(carry_cnt);
      end
    end
  end

  assign bus.result_count = result_cnt;
  assign bus.carry_count  = carry_cnt;
`endif

endmodule

// File: tb/tb_sync_adder.sv
// tb_sync_adder: drives a LATENCY=1 and a LATENCY=3 instance with identical
// stimulus and compares each against a queue-based scoreboard.
module tb_sync_adder;

  typedef struct {
    logic [8:0] s;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  exp_t q1[$];
  exp_t q3[$];
  logic [8:0] last1 = '0;
  logic [8:0] last3 = '0;
  int   exp_res = 0;
  int   exp_carry = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_adder_if #(.WIDTH(8)) if1 ();
  sync_adder_if #(.WIDTH(8)) if3 ();

  sync_adder #(.WIDTH(8), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  sync_adder #(.WIDTH(8), .LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Apply one cycle of inputs just after the falling edge; the next rising
  // edge samples them.
  task automatic drive(input logic r, input logic en, input logic [7:0] aa, input logic [7:0] bb);
    exp_t e;
    logic [8:0] s;
    @(negedge clk);
    #1;
    rst = r;
    if1.enable = en; if1.a = aa; if1.b = bb;
    if3.enable = en; if3.a = aa; if3.b = bb;
    if (r) begin
      q1.delete();
      q3.delete();
      last1 = '0;
      last3 = '0;
      exp_res = 0;
      exp_carry = 0;
    end else if (en) begin
      s = {1'b0, aa} + {1'b0, bb};
      exp_res++;
      if (s[8]) exp_carry++;
      e.s = s;
      e.due = cyc + 1;
      q1.push_back(e);
      e.due = cyc + 3;
      q3.push_back(e);
    end
  endtask

  // Scoreboard for the LATENCY=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e = q1.pop_front();
        chk("l1_valid", 64'(if1.valid), 64'd1);
        chk("l1_sum", 64'(if1.sum), 64'(e.s));
        last1 = e.s;
      end else begin
        chk("l1_idle_valid", 64'(if1.valid), 64'd0);
        chk("l1_hold_sum", 64'(if1.sum), 64'(last1));
      end
    end
  end

  // Scoreboard for the LATENCY=3 instance.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (q3.size() > 0 && q3[0].due == cyc) begin
        e = q3.pop_front();
        chk("l3_valid", 64'(if3.valid), 64'd1);
        chk("l3_sum", 64'(if3.sum), 64'(e.s));
        last3 = e.s;
      end else begin
        chk("l3_idle_valid", 64'(if3.valid), 64'd0);
        chk("l3_hold_sum", 64'(if3.sum), 64'(last3));
      end
    end
  end

  initial begin
    if1.enable = 1'b0; if1.a = '0; if1.b = '0;
    if3.enable = 1'b0; if3.a = '0; if3.b = '0;

    // reset for two edges, then explicit reset-state checks
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    @(posedge clk);
    #1;
    chk("rst_l1_sum", 64'(if1.sum), 64'd0);
    chk("rst_l1_valid", 64'(if1.valid), 64'd0);
    chk("rst_l3_sum", 64'(if3.sum), 64'd0);
    chk("rst_l3_valid", 64'(if3.valid), 64'd0);
`ifdef SYNC_ADDER_STATS_EN
    chk("rst_l3_rcount", 64'(if3.result_count), 64'd0);
    chk("rst_l3_ccount", 64'(if3.carry_count), 64'd0);
`endif
    mon_en = 1'b1;

    // directed: basic, carry, disable-hold, zero, max
    drive(1'b0, 1'b1, 8'd65, 8'd55);
    drive(1'b0, 1'b1, 8'd200, 8'd100);
    drive(1'b0, 1'b0, 8'd50, 8'd50);
    drive(1'b0, 1'b1, 8'd50, 8'd50);
    drive(1'b0, 1'b1, 8'd0, 8'd0);
    drive(1'b0, 1'b1, 8'd255, 8'd255);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'd7, 8'd9);

    // reset in the middle of a stream: in-flight pairs must vanish
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 8'($urandom), 8'($urandom));
    drive(1'b1, 1'b1, 8'd123, 8'd45);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'd1, 8'd2);

    // full-throughput sweep after a fresh reset
    drive(1'b1, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b1, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'd0, 8'd0);

`ifdef SYNC_ADDER_STATS_EN
    chk("l3_result_count", 64'(if3.result_count), 64'd100);
    chk("l3_carry_count", 64'(if3.carry_count), 64'(exp_carry));
    chk("l1_result_count", 64'(if1.result_count), 64'(exp_res));
    chk("l1_carry_count", 64'(if1.carry_count), 64'(exp_carry));
`endif

    // every expected result must have been delivered
    chk("l1_drain", 64'(q1.size()), 64'd0);
    chk("l3_drain", 64'(q3.size()), 64'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_adder.md
Name: sync_adder

Overview:
- Registered unsigned adder with enable-qualified valid output. Sits in datapath glue wherever a clocked A+B with carry preserved is needed.
- Operands are sampled on a rising clk edge while enable=1. The full-precision sum and a valid strobe appear LATENCY cycles later.
- Pipeline depth is parameterised. An optional statistics block is available.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..64.
- LATENCY, 1, number of register stages from operand sample to sum/valid; legal range 1..4. Out-of-range values are clamped to 1 at elaboration.

Ports:
- clk  in  1  rising-edge clock; all state updates here.
- rst  in  1  synchronous active-high reset.
- enable  in  1  qualifies a and b for sampling this cycle.
- a  in  WIDTH  unsigned operand A.
- b  in  WIDTH  unsigned operand B.
- sum  out  WIDTH+1  registered a+b; MSB is the carry-out.
- valid  out  1  high for one cycle per accepted operand pair, aligned with its sum.

Behaviour:
- Reset:
  - rst sampled high at a clk edge clears all pipeline stages.
  - sum=0 and valid=0 from the following edge onward.
  - rst has priority over enable.
  - Reset mid-operation discards all in-flight results; no valid emitted for them.
- Arithmetic:
  - sum = zero-extend(a) + zero-extend(b), WIDTH+1 bits, unsigned.
  - No wrap or saturation; 255+255 gives 510 for WIDTH=8.
- Acceptance: edge N with enable=1 captures a/b. Result appears on sum with valid=1 after edge N+LATENCY-1 (LATENCY=1: registered output immediately after edge N).
- Stage tagging: each stage carries a valid bit plus data. Stage valid = previous stage valid (stage 0 valid = enable).
- Hold rule: a stage's data register updates only when its incoming valid=1. With enable=0, sum holds the last produced result while valid=0; sum never returns to 0 except by reset.
- Streaming: enable held high accepts one pair per cycle at full throughput. No backpressure; no stalls.
- Operand changes while enable=1 are sampled every cycle. Each cycle produces an independent result.
- Inputs are assumed synchronous to clk. No internal CDC.

Optional Feature:
- Macro: SYNC_ADDER_STATS_EN.
- When defined, the block adds two outputs, each reset to 0 by rst and saturating at all-ones (no wrap):
  - result_count: out, 32 bits; increments on every cycle valid=1.
  - carry_count: out, 32 bits; increments on every cycle valid=1 with sum[WIDTH]=1.
- When not defined, these ports and their counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- Reset then basic add: rst=1 for 2 cycles, release, enable=1, a=65, b=55. One cycle later: sum=120, valid=1.
- Carry: a=200, b=100, enable=1. Next cycle: sum=300 (bit 8 set), valid=1.
- Disable hold: enable=0, a=50, b=50. Next cycle: valid=0, sum stays 300. Then enable=1: next cycle sum=100, valid=1.
- Boundaries: a=0, b=0 gives sum=0, valid=1. a=255, b=255 gives sum=510, valid=1.
- Reset mid-stream: enable=1 streaming, assert rst for one cycle. Next cycle: sum=0, valid=0, and no stale valid afterwards. With LATENCY=3, the in-flight pairs are dropped.
- Throughput/latency sweep: LATENCY=3, back-to-back random pairs for 100 cycles. Each sum matches a+b exactly 3 cycles after its sample. With SYNC_ADDER_STATS_EN defined, result_count=100 and carry_count equals the number of carry-producing pairs.
